// File: rtl/arp_pkg.sv
// Shared types and field positions for the ARP table sequencer.
// Entries are {mac_field[63:0], next_hop_ip[31:0]}.
package arp_pkg;

  localparam int unsigned ENTRY_W = 96;
  localparam int unsigned IP_LSB  = 0;
  localparam int unsigned IP_MSB  = 31;
  localparam int unsigned MAC_LSB = 32;
  localparam int unsigned MAC_MSB = 95;
  localparam int unsigned IP_W    = IP_MSB - IP_LSB + 1;
  localparam int unsigned MAC_W   = MAC_MSB - MAC_LSB + 1;
  localparam int unsigned OQ_W    = 32;

  localparam logic [IP_W-1:0] INVALID_IP = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StResp,
    StHostWr,
    StHostRd
  } arp_state_e;

  typedef enum logic {
    GrantHost,
    GrantLkp
  } arp_grant_e;

endpackage

// File: rtl/arp_table_sched_if.sv
// Host table access and next-hop lookup signals of the ARP table sequencer.
// master drives requests, slave is the table controller.
interface arp_table_sched_if #(
  parameter int unsigned IDX_W = 5
);
  import arp_pkg::*;

  logic               tbl_wr_req;
  logic [IDX_W-1:0]   tbl_wr_addr;
  logic [ENTRY_W-1:0] tbl_wr_data;
  logic               tbl_wr_ack;
  logic               tbl_rd_req;
  logic [IDX_W-1:0]   tbl_rd_addr;
  logic [ENTRY_W-1:0] tbl_rd_data;
  logic               tbl_rd_ack;

  logic               lkp_req;
  logic [IP_W-1:0]    lkp_nh_ip;
  logic [OQ_W-1:0]    lkp_oq;
  logic               lkp_ready;
  logic               lkp_done;
  logic               lkp_hit;
  logic [IDX_W-1:0]   lkp_index;
  logic [MAC_W-1:0]   lkp_mac;
  logic [OQ_W-1:0]    lkp_oq_out;

  modport master (
    output tbl_wr_req, tbl_wr_addr, tbl_wr_data, tbl_rd_req, tbl_rd_addr,
    output lkp_req, lkp_nh_ip, lkp_oq,
    input  tbl_wr_ack, tbl_rd_data, tbl_rd_ack,
    input  lkp_ready, lkp_done, lkp_hit, lkp_index, lkp_mac, lkp_oq_out
  );

  modport slave (
    input  tbl_wr_req, tbl_wr_addr, tbl_wr_data, tbl_rd_req, tbl_rd_addr,
    input  lkp_req, lkp_nh_ip, lkp_oq,
    output tbl_wr_ack, tbl_rd_data, tbl_rd_ack,
    output lkp_ready, lkp_done, lkp_hit, lkp_index, lkp_mac, lkp_oq_out
  );

endinterface

// File: rtl/arp_entry_cmp.sv
// Match of one table entry's IP field against a lookup IP.
// All-ones IP marks an invalid entry and never matches.
module arp_entry_cmp
  import arp_pkg::*;
(
  input  logic [IP_W-1:0] entry_ip_i,
  input  logic [IP_W-1:0] ip_i,
  output logic            match_o
);

  always_comb begin
    match_o = (entry_ip_i == ip_i) && (entry_ip_i != INVALID_IP);
  end

endmodule

// File: rtl/arp_table_sched.sv
// 32-entry ARP table with sequential early-exit lookup, arbitrated against
// host reads/writes, plus hit/miss statistics.
module arp_table_sched
  import arp_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_ENTRIES        = 32,
  parameter int unsigned IDX_W              = 5
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESET,
  arp_table_sched_if.slave              bus,
  output logic [C_S_AXI_DATA_WIDTH-1:0] hit_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] miss_count
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ENTRIES - 1);

  arp_state_e state_q, state_d;
  arp_grant_e last_q, last_d;

  logic [ENTRY_W-1:0] arp_tbl_q [NUM_ENTRIES];

  logic                          wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]              wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [ENTRY_W-1:0]            wr_data_q, wr_data_d;
  logic [IP_W-1:0]               ip_q, ip_d;
  logic [OQ_W-1:0]               oq_q, oq_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          found_q, found_d;
  logic                          wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic [ENTRY_W-1:0]            rd_data_q, rd_data_d;
  logic                          done_q, done_d, hit_q, hit_d;
  logic [IDX_W-1:0]              index_q, index_d;
  logic [MAC_W-1:0]              mac_q, mac_d;
  logic [OQ_W-1:0]               oq_out_q, oq_out_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic host_pend, ready, cur_match, tbl_we;

  arp_entry_cmp u_cmp (
    .entry_ip_i (arp_tbl_q[idx_q][IP_MSB:IP_LSB]),
    .ip_i       (ip_q),
    .match_o    (cur_match)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wr_pend_d  = wr_pend_q;
    rd_pend_d  = rd_pend_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_data_d  = wr_data_q;
    ip_d       = ip_q;
    oq_d       = oq_q;
    idx_d      = idx_q;
    found_d    = found_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    hit_d      = hit_q;
    index_d    = index_q;
    mac_d      = mac_q;
    oq_out_d   = oq_out_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    tbl_we     = 1'b0;

    host_pend = wr_pend_q | rd_pend_q;
    // After a lookup grant, a pending host op gets the next slot.
    ready = (state_q == StIdle) && !(last_q == GrantLkp && host_pend);

    unique case (state_q)
      StIdle: begin
        if (ready && bus.lkp_req) begin
          state_d = StSearch;
          last_d  = GrantLkp;
          ip_d    = bus.lkp_nh_ip;
          oq_d    = bus.lkp_oq;
          idx_d   = '0;
          found_d = 1'b0;
        end else if (wr_pend_q) begin
          state_d = StHostWr;
          last_d  = GrantHost;
        end else if (rd_pend_q) begin
          state_d = StHostRd;
          last_d  = GrantHost;
        end
      end
      StSearch: begin
        if (cur_match) begin
          found_d = 1'b1;
          state_d = StResp;
        end else if (idx_q == LastIdx) begin
          state_d = StResp;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StResp: begin
        done_d   = 1'b1;
        hit_d    = found_q;
        index_d  = found_q ? idx_q : '0;
        mac_d    = found_q ? arp_tbl_q[idx_q][MAC_MSB:MAC_LSB] : '0;
        oq_out_d = oq_q;
        if (found_q) hit_cnt_d = hit_cnt_q + C_S_AXI_DATA_WIDTH'(1);
        else         miss_cnt_d = miss_cnt_q + C_S_AXI_DATA_WIDTH'(1);
        state_d  = StIdle;
      end
      StHostWr: begin
        tbl_we    = 1'b1;
        wr_ack_d  = 1'b1;
        wr_pend_d = 1'b0;
        state_d   = StIdle;
      end
      StHostRd: begin
        rd_data_d = arp_tbl_q[rd_addr_q];
        rd_ack_d  = 1'b1;
        rd_pend_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // New host pulses are captured in any state; a fresh pulse outranks a completion clear.
    if (bus.tbl_wr_req) begin
      wr_pend_d = 1'b1;
      wr_addr_d = bus.tbl_wr_addr;
      wr_data_d = bus.tbl_wr_data;
    end
    if (bus.tbl_rd_req) begin
      rd_pend_d = 1'b1;
      rd_addr_d = bus.tbl_rd_addr;
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q    <= StIdle;
      last_q     <= GrantHost;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_data_q  <= '0;
      ip_q       <= '0;
      oq_q       <= '0;
      idx_q      <= '0;
      found_q    <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      index_q    <= '0;
      mac_q      <= '0;
      oq_out_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_data_q  <= wr_data_d;
      ip_q       <= ip_d;
      oq_q       <= oq_d;
      idx_q      <= idx_d;
      found_q    <= found_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      index_q    <= index_d;
      mac_q      <= mac_d;
      oq_out_q   <= oq_out_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      for (int i = 0; i < NUM_ENTRIES; i++) arp_tbl_q[i] <= '1;
    end else if (tbl_we) begin
      arp_tbl_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign bus.tbl_wr_ack  = wr_ack_q;
  assign bus.tbl_rd_ack  = rd_ack_q;
  assign bus.tbl_rd_data = rd_data_q;
  assign bus.lkp_ready   = ready;
  assign bus.lkp_done    = done_q;
  assign bus.lkp_hit     = hit_q;
  assign bus.lkp_index   = index_q;
  assign bus.lkp_mac     = mac_q;
  assign bus.lkp_oq_out  = oq_out_q;
  assign hit_count       = hit_cnt_q;
  assign miss_count      = miss_cnt_q;

endmodule
